// File: rtl/barrel_shifter_pipe_if.sv
// ============================================================================
// barrel_shifter_pipe_if : valid/ready operand and result bundle for barrel_shifter_pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

interface barrel_shifter_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int LG = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LG-1:0]    in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
// ============================================================================
// barrel_shifter_pipe : LG-stage pipelined ROL/ROR/SLL/SRL/SRA/PASS shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

module barrel_shifter_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  barrel_shifter_pipe_if.slave bus
);
  localparam int LG = $clog2(WIDTH);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  logic             advance;
  logic [WIDTH-1:0] data_q  [LG];
  logic [WIDTH-1:0] data_d  [LG];
  logic [LG-1:0]    amt_q   [LG];
  logic [LG-1:0]    amt_d   [LG];
  logic [2:0]       op_q    [LG];
  logic [2:0]       op_d    [LG];
  logic             sgn_q   [LG];
  logic             sgn_d   [LG];
  logic [LG-1:0]    valid_q;
  logic [LG-1:0]    valid_d;
  logic             zero_q;
  logic             zero_d;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic [2:0]       op,
    input logic             sgn,
    input logic             en,
    input int               s
  );
    logic [WIDTH-1:0] fill;
    fill       = ~({WIDTH{1'b1}} >> s);
    shift_step = v;
    if (en) begin
      case (op)
        OP_ROL:  shift_step = (v << s) | (v >> (WIDTH - s));
        OP_ROR:  shift_step = (v >> s) | (v << (WIDTH - s));
        OP_SLL:  shift_step = v << s;
        OP_SRL:  shift_step = v >> s;
        OP_SRA:  shift_step = (v >> s) | (sgn ? fill : '0);
        default: shift_step = v;
      endcase
    end
  endfunction

  always_comb begin
    advance = !valid_q[LG-1] || bus.out_ready;
    valid_d = valid_q;
    zero_d  = zero_q;
    for (int k = 0; k < LG; k++) begin
      data_d[k] = data_q[k];
      amt_d[k]  = amt_q[k];
      op_d[k]   = op_q[k];
      sgn_d[k]  = sgn_q[k];
    end
    if (advance) begin
      // Bubbles move through valid only; stage payloads load just for real beats.
      valid_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        data_d[0] = shift_step(bus.in_data, bus.in_op, bus.in_data[WIDTH-1], bus.in_amt[0], 1);
        amt_d[0]  = bus.in_amt >> 1;
        op_d[0]   = bus.in_op;
        sgn_d[0]  = bus.in_data[WIDTH-1];
      end
      for (int k = 1; k < LG; k++) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = shift_step(data_q[k-1], op_q[k-1], sgn_q[k-1], amt_q[k-1][0], 1 << k);
          amt_d[k]  = amt_q[k-1] >> 1;
          op_d[k]   = op_q[k-1];
          sgn_d[k]  = sgn_q[k-1];
        end
      end
      if (valid_q[LG-2]) begin
        zero_d = (data_d[LG-1] == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      zero_q  <= 1'b1;
      for (int k = 0; k < LG; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        op_q[k]   <= '0;
        sgn_q[k]  <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      zero_q  <= zero_d;
      for (int k = 0; k < LG; k++) begin
        data_q[k] <= data_d[k];
        amt_q[k]  <= amt_d[k];
        op_q[k]   <= op_d[k];
        sgn_q[k]  <= sgn_d[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_q[LG-1];
  assign bus.out_data  = data_q[LG-1];
  assign bus.out_zero  = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
// ============================================================================
// tb_barrel_shifter_pipe : directed checks of barrel_shifter_pipe at WIDTH=32
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_barrel_shifter_pipe;
  localparam int WIDTH = 32;
  localparam int LG    = 5;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   sent;
  int   got;

  logic [31:0] stream_exp [10] = '{32'h1, 32'h4, 32'hC, 32'h20, 32'h50,
                                   32'hC0, 32'h1C0, 32'h400, 32'h900, 32'h1400};

  always #5 clk = ~clk;

  barrel_shifter_pipe_if #(.WIDTH(WIDTH)) bus ();

  barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one beat into an empty pipe and checks latency, result and zero flag.
  task automatic run_vec(input string tag, input logic [2:0] op, input logic [4:0] amt,
                         input logic [31:0] data, input logic [31:0] exp, input logic expz);
    int lat;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_amt    = amt;
    bus.in_data   = data;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(LG - 1));
    check({tag, " data"}, 64'(bus.out_data), 64'(exp));
    check({tag, " zero"}, 64'(bus.out_zero), 64'(expz));
    step();
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.in_amt    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset out_data",  64'(bus.out_data),  64'd0);
    check("reset out_zero",  64'(bus.out_zero),  64'd1);
    check("reset in_ready",  64'(bus.in_ready),  64'd1);
    reset = 1'b0;
    step();

    run_vec("rol",     3'b000, 5'd1,  32'h80000001, 32'h00000003, 1'b0);
    run_vec("ror",     3'b001, 5'd4,  32'h00000001, 32'h10000000, 1'b0);
    run_vec("srl",     3'b011, 5'd31, 32'h80000000, 32'h00000001, 1'b0);
    run_vec("sll",     3'b010, 5'd31, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_vec("pass",    3'b101, 5'd7,  32'h00001234, 32'h00001234, 1'b0);
    run_vec("pass7",   3'b111, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    run_vec("sra neg", 3'b100, 5'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_vec("sra pos", 3'b100, 5'd31, 32'h7FFFFFFF, 32'h00000000, 1'b1);
    run_vec("rol0",    3'b000, 5'd0,  32'h12345678, 32'h12345678, 1'b0);
    run_vec("ror8",    3'b001, 5'd8,  32'h000000F0, 32'hF0000000, 1'b0);
    run_vec("sra mid", 3'b100, 5'd4,  32'h80000010, 32'hF8000001, 1'b0);

    // Ten-beat stream with out_ready low for cycles 8..10.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      bus.in_valid  = (sent < 10);
      bus.in_op     = 3'b000;
      bus.in_amt    = sent[4:0];
      bus.in_data   = 32'(sent + 1);
      bus.out_ready = !(cyc >= 8 && cyc <= 10);
      #1;
      if (!bus.out_ready) check("stall in_ready", 64'(bus.in_ready), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("stream beat %0d", got), 64'(bus.out_data), 64'(stream_exp[got]));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream emitted", 64'(got), 64'd10);
    check("stream sent",    64'(sent), 64'd10);
    step();
    step();
    check("stream no dup", 64'(bus.out_valid), 64'd0);

    // Reset with three beats in flight: none may ever emerge.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = 3'b010;
      bus.in_amt   = 5'd1;
      bus.in_data  = 32'(i + 1);
      step();
      check("inflight out_valid", 64'(bus.out_valid), 64'd0);
    end
    bus.in_valid = 1'b0;
    step();
    check("pre-reset out_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b1;
    step();
    check("midreset out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset out_zero",  64'(bus.out_zero),  64'd1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post-reset idle", 64'(bus.out_valid), 64'd0);
    end
    run_vec("after reset", 3'b010, 5'd4, 32'h00000001, 32'h00000010, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
